// File: rtl/cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfg_pkg -- shared state type, default table/timing constants, helper |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cfg_pkg;

  localparam int MEM_DEPTH      = 512;
  localparam int PREAMBLE_LEN   = 3;
  localparam int SETTLE_CYCLES  = 30_000_000;
  localparam int GAP_CYCLES     = 16;
  localparam int TIMEOUT_CYCLES = 1_000_000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    GAP       = 3'd3,
    SETTLE    = 3'd4,
    FINISH    = 3'd5
  } seq_state_t;

  // Width of the shared delay counter: enough to hold the longest delay.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_delay_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfg_delay_cnt -- loadable down-counter, expires at 1, never wraps    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cfg_delay_cnt
  import cfg_pkg::*;
#(
  parameter int WIDTH = cnt_width(SETTLE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             expired
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value > WIDTH'(1)) begin
      value <= value - WIDTH'(1);
    end
  end

  assign expired = (value == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/si5340_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | si5340_cfg_sequencer -- walks the Si5340 register table via loader;  |
// | optional stuck-loader timeout with SEQ_TIMEOUT_EN. Rev 1.0           |
// +----------------------------------------------------------------------+
module si5340_cfg_sequencer #(
  parameter int MEM_DEPTH      = cfg_pkg::MEM_DEPTH,
  parameter int PREAMBLE_LEN   = cfg_pkg::PREAMBLE_LEN,
  parameter int SETTLE_CYCLES  = cfg_pkg::SETTLE_CYCLES,
  parameter int GAP_CYCLES     = cfg_pkg::GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = cfg_pkg::TIMEOUT_CYCLES
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic                         start_i,
  input  logic                         mode_i,
  output logic                         load_o,
  output logic                         write_o,
  input  logic                         done_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [$clog2(MEM_DEPTH)-1:0] entry_o
);
  import cfg_pkg::*;

  localparam int EW    = $clog2(MEM_DEPTH);
  localparam int CNT_W = cnt_width(SETTLE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [EW-1:0] LAST_ENTRY = EW'(MEM_DEPTH - 1);
  localparam logic [EW-1:0] PRE_LAST   = EW'(PREAMBLE_LEN - 1);

  seq_state_t       state;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic [CNT_W-1:0] cnt_now;
  logic             cnt_expired;

  // Counter is loaded on the same edge the FSM enters a timed state.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      ISSUE: begin
`ifdef SEQ_TIMEOUT_EN
        cnt_load  = 1'b1;
        cnt_value = CNT_W'(TIMEOUT_CYCLES);
`endif
      end
      WAIT_DONE: begin
        if (done_i && (entry_o != LAST_ENTRY)) begin
          cnt_load  = 1'b1;
          cnt_value = (write_o && (entry_o == PRE_LAST)) ? CNT_W'(SETTLE_CYCLES)
                                                         : CNT_W'(GAP_CYCLES);
        end
      end
      default: ;
    endcase
  end

  cfg_delay_cnt #(
    .WIDTH (CNT_W)
  ) u_delay (
    .clk        (clk_i),
    .rstn       (arstn_i),
    .load       (cnt_load),
    .load_value (cnt_value),
    .value      (cnt_now),
    .expired    (cnt_expired)
  );

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state   <= IDLE;
      load_o  <= 1'b0;
      write_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      entry_o <= '0;
`ifdef SEQ_TIMEOUT_EN
      err_o   <= 1'b0;
`endif
    end else begin
      load_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            write_o <= mode_i;
            entry_o <= '0;
            busy_o  <= 1'b1;
            load_o  <= 1'b1;
            state   <= ISSUE;
`ifdef SEQ_TIMEOUT_EN
            err_o   <= 1'b0;
`endif
          end
        end
        ISSUE: state <= WAIT_DONE;
        WAIT_DONE: begin
          // A completion arriving on the expiry cycle still counts.
          if (done_i) begin
            if (entry_o == LAST_ENTRY) begin
              entry_o <= '0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              state   <= FINISH;
            end else begin
              entry_o <= entry_o + EW'(1);
              state   <= (write_o && (entry_o == PRE_LAST)) ? SETTLE : GAP;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (cnt_expired) begin
            busy_o <= 1'b0;
            err_o  <= 1'b1;
            state  <= IDLE;
          end
`endif
        end
        GAP, SETTLE: begin
          if (cnt_expired) begin
            load_o <= 1'b1;
            state  <= ISSUE;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SEQ_TIMEOUT_EN
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/si5340_cfg_sequencer.md
# si5340_cfg_sequencer

Top-level sequencer that walks the whole Si5340 register table by issuing one `load`/`write` request per entry to the per-entry I2C config loader, which sits directly downstream. It waits for the loader's per-entry completion and paces successive entries. After the preamble entries, it inserts the mandatory device settle delay. It reports progress, completion and (optionally) a stuck-transaction error to the system controller.

## Interface
Parameters:
- `MEM_DEPTH`, `cfg_pkg::MEM_DEPTH` — number of table entries; must equal the loader's table depth.
- `PREAMBLE_LEN`, 3 — entries forming the preamble; settle delay follows entry `PREAMBLE_LEN-1`; range 1..MEM_DEPTH-1.
- `SETTLE_CYCLES`, 30_000_000 — post-preamble settle (300 ms at 100 MHz); ≥1.
- `GAP_CYCLES`, 16 — idle cycles between entries; ≥1.
- `TIMEOUT_CYCLES`, 1_000_000 — max wait for loader completion (only with `SEQ_TIMEOUT_EN`).

Ports:
- `clk_i`  in  1  — single clock.
- `arstn_i`  in  1  — reset, synchronous, active-low.
- `start_i`  in  1  — pulse; begins a pass when idle.
- `mode_i`  in  1  — 1 = write pass, 0 = readback pass; sampled with `start_i`.
- `load_o`  out  1  — one-cycle request to loader (`load_i`).
- `write_o`  out  1  — to loader `write_i`; constant for the whole pass.
- `done_i`  in  1  — loader per-entry completion pulse.
- `busy_o`  out  1  — pass in progress.
- `done_o`  out  1  — one-cycle pulse; pass completed.
- `err_o`  out  1  — sticky timeout flag.
- `entry_o`  out  `$clog2(MEM_DEPTH)`  — index of current or next entry.

## Operation
- Reset values: `load_o`=0, `write_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `entry_o`=0, state IDLE, all counters 0.
- IDLE: on `start_i`, latch `mode_i` into `write_o`, clear `err_o`, set `entry_o`=0 and `busy_o`=1, go to ISSUE. `start_i` is ignored in every other state.
- ISSUE: `load_o`=1 for exactly this cycle; go to WAIT_DONE.
- WAIT_DONE: on `done_i`:
  - if `entry_o`==MEM_DEPTH-1, go to FINISH; `entry_o` wraps to 0.
  - else if `write_o`=1 and `entry_o`==PREAMBLE_LEN-1, go to SETTLE; `entry_o`+1.
  - else go to GAP; `entry_o`+1.
- GAP: stay GAP_CYCLES cycles, then go to ISSUE.
- SETTLE: stay SETTLE_CYCLES cycles, then go to ISSUE. In a readback pass, SETTLE is never entered.
- FINISH: `done_o`=1 for this cycle and `busy_o`=0; go to IDLE.
- `done_i` outside WAIT_DONE is ignored.
- Reset asserted mid-pass returns everything to reset values on that edge. The loader shares the reset, so both indices realign.
- Delay counter width is `$clog2(max(SETTLE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)+1)`. It loads on entry to a delay state and counts down to 1; there is no wrap.

## Timing
- `start_i` at cycle t → `load_o` high at t+1 → WAIT_DONE from t+2.
- `done_i` at cycle t (non-last entry) → next `load_o` at t+1+GAP_CYCLES, or t+1+SETTLE_CYCLES after the preamble.
- `done_i` on the last entry at t → `done_o` at t+1; idle at t+2; a new `start_i` is accepted from t+2.
- `done_i` in the same cycle as the timeout expiry: `done_i` wins.
- All outputs are registered-state decodes with no combinational input-to-output path.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - WAIT_DONE loads the counter with TIMEOUT_CYCLES.
  - If the counter expires without `done_i`, go to IDLE with `err_o`=1, `busy_o`=0 and no `done_o`; `entry_o` holds the failing index.
- `SEQ_TIMEOUT_EN` undefined: WAIT_DONE waits indefinitely; `err_o` is tied to 0.

## Structure
- `cfg_pkg` holds:
  - the `seq_state_t` enum: IDLE, ISSUE, WAIT_DONE, GAP, SETTLE, FINISH.
  - defaults for MEM_DEPTH, PREAMBLE_LEN, SETTLE_CYCLES, GAP_CYCLES and TIMEOUT_CYCLES.
- One sub-module, `cfg_delay_cnt`: loadable down-counter with `load`, `value` and `expired` ports. It is shared by GAP, SETTLE and the timeout.

## Test plan
Test parameters: MEM_DEPTH=4, PREAMBLE_LEN=2, GAP_CYCLES=3, SETTLE_CYCLES=20, TIMEOUT_CYCLES=50; the loader model answers `done_i` 5 cycles after `load_o`.
- Write pass: `start_i`, `mode_i`=1 → 4 `load_o` pulses; load→load spacing is 9, 26 (settle), 9 cycles; `done_o` 1 cycle after the 4th `done_i`; `entry_o` ends at 0.
- Readback pass, `mode_i`=0 → `write_o`=0 throughout; no settle; every spacing is 9 cycles.
- `start_i` pulsed while `busy_o`=1 → no extra `load_o`; `mode_i` change is ignored.
- With `SEQ_TIMEOUT_EN`, model withholds `done_i` on entry 2 → `err_o`=1 exactly 51 cycles after that `load_o`; `busy_o`=0; `entry_o`=2; a new `start_i` clears `err_o`.
- `arstn_i` low during SETTLE → next cycle all outputs are at reset values; a subsequent `start_i` restarts at entry 0.
- Spurious `done_i` during GAP → ignored; `entry_o` and `load_o` timing unchanged.
